fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter controller that sequences the 9-bit-wide instruction ROM. It owns the program counter that addresses the ROM, and it starts, advances, stalls, jumps, branches and halts program execution from decoder/datapath control inputs. It sits between the instruction decoder and the ROM address port. It reports run status and an executed-cycle count to the testbench and top level.

## Interface
Parameters:
- D, 9, program-counter width; the ROM depth is 2**D words.
- OFF_W, 8, width of the signed relative branch offset.
- CNT_W, 16, width of the run-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begins execution at start_addr; honoured only in IDLE or DONE.
- start_addr  in  D  first instruction address.
- stall  in  1  holds the PC for this cycle (datapath busy).
- halt  in  1  decoded halt instruction; ends execution.
- jump  in  1  absolute jump request.
- jump_target  in  D  absolute target address.
- branch  in  1  taken relative branch request.
- branch_off  in  OFF_W  signed two's-complement offset, relative to the current PC.
- prog_ctr  out  D  ROM address (registered).
- fetch_valid  out  1  high when prog_ctr addresses an instruction being executed (RUN state).
- done  out  1  high in DONE state.
- cycle_cnt  out  CNT_W  count of RUN cycles since the last start.

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n low, any time, asynchronous): state=IDLE, prog_ctr=0, fetch_valid=0, done=0, cycle_cnt=0.
- IDLE/DONE with start=1:
  - state→RUN, prog_ctr←start_addr, cycle_cnt←0, done←0.
  - All other inputs are ignored in IDLE/DONE.
- RUN: inputs are evaluated with fixed priority, highest first:
  1. halt: state→DONE, prog_ctr holds. This applies even if stall is high.
  2. stall: prog_ctr holds; jump/branch this cycle are discarded. The decoder re-presents them once the stall drops.
  3. jump: prog_ctr←jump_target.
  4. branch: prog_ctr←(prog_ctr + sign-extended branch_off) mod 2**D.
  5. otherwise: prog_ctr←(prog_ctr+1) mod 2**D. Incrementing from 2**D-1 wraps to 0 and is legal.
- start asserted while in RUN is ignored.
- jump and branch both high: jump wins.
- cycle_cnt:
  - Increments by 1 every RUN cycle, including stall cycles and the halt cycle.
  - Saturates at 2**CNT_W-1.
  - Holds in IDLE/DONE until the next start.
- fetch_valid = (state==RUN); done = (state==DONE). Both are decoded from the state register.

## Timing
- prog_ctr is a register. The ROM is combinational, so the instruction at prog_ctr is available in the same cycle.
- Control inputs are sampled on the rising edge and affect prog_ctr on that edge. A jump/branch decoded from instruction N therefore makes the target the next address, with no delay slot and no bubble.
- Start latency: start sampled at edge k gives fetch_valid=1 and prog_ctr=start_addr after edge k.
- Halt latency: halt sampled at edge k gives fetch_valid=0 and done=1 after edge k. prog_ctr keeps the halt instruction's address.
- Reset assertion clears all outputs immediately, without waiting for clk. Deassertion takes effect at the next edge; no start is accepted on the edge coincident with deassertion.

## Test plan
- Reset/start:
  - rst_n=0 for 2 cycles: prog_ctr=0, fetch_valid=0, done=0, cycle_cnt=0.
  - Release, then start with start_addr=5: next cycle prog_ctr=5, fetch_valid=1.
  - Four free cycles: prog_ctr=6,7,8,9.
- Branch/jump:
  - At prog_ctr=20, branch with branch_off=8'hFD (-3) → prog_ctr=17.
  - At prog_ctr=17, jump and branch both high with jump_target=100 → prog_ctr=100.
- Stall and wrap:
  - At prog_ctr=511, stall for 3 cycles → prog_ctr stays 511 and cycle_cnt advances by 3.
  - Release stall → prog_ctr=0.
  - Branch from 2 with offset -4 → prog_ctr=510.
- Halt:
  - At prog_ctr=40, halt with stall=1 → DONE; done=1, fetch_valid=0, prog_ctr=40.
  - cycle_cnt frozen; start_addr=0 with start → RUN at 0, cycle_cnt restarts at 0.
- Mid-run reset:
  - In RUN at prog_ctr=77, pulse rst_n low between edges → outputs clear asynchronously to IDLE/0.
  - start held high across the rst_n release edge is ignored; start on the following edge is honoured.
- Ignored inputs:
  - start in RUN with start_addr=300 → PC continues incrementing.
  - jump in IDLE → prog_ctr remains 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start/advance/stall/jump/branch/halt.
// Latency: control sampled on a rising edge takes effect on prog_ctr at that same edge.
// Backpressure: stall holds prog_ctr, and a jump/branch presented during a stall is dropped.
module fetch_sequencer #(
  parameter int D     = 9,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [D-1:0]     start_addr,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump,
  input  logic [D-1:0]     jump_target,
  input  logic             branch,
  input  logic [OFF_W-1:0] branch_off,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  // The adder is wide enough for both the PC and the offset, so the sign
  // extension stays well-formed even if OFF_W is not smaller than D.
  localparam int SW = (D > OFF_W) ? D : OFF_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [D-1:0]     pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Cleared by reset and set by the first clock edge after release. This
  // keeps a start that is held across reset release from being taken on the
  // edge that coincides with the release.
  logic start_armed;

  logic signed [OFF_W-1:0] off_s;
  logic signed [SW-1:0]    off_sx;
  logic [SW-1:0]           pc_sum;
  logic [D-1:0]            pc_branch;
  logic [D-1:0]            pc_inc;

  // Relative branch target. Only the low D bits are kept, so the result
  // wraps modulo the ROM depth in both directions.
  assign off_s     = branch_off;
  assign off_sx    = SW'(off_s);
  assign pc_sum    = SW'(prog_ctr) + off_sx;
  assign pc_branch = pc_sum[D-1:0];
  assign pc_inc    = prog_ctr + D'(1);

  // Status outputs are decoded straight from the state register.
  assign fetch_valid = (state == ST_RUN);
  assign done        = (state == ST_DONE);

  // Start-qualification flag: low in reset, high from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_armed <= 1'b0;
    end else begin
      start_armed <= 1'b1;
    end
  end

  // State, program counter and cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prog_ctr  <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prog_ctr  <= pc_nxt;
      cycle_cnt <= cnt_nxt;
    end
  end

  // Next-state, next-PC and counter logic. In RUN the controls are resolved
  // in priority order: halt, then stall, then jump, then branch, then increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    cnt_nxt   = cycle_cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        // Only start matters here; every other control input is ignored.
        if (start && start_armed) begin
          state_nxt = ST_RUN;
          pc_nxt    = start_addr;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        // Every RUN cycle is counted, including stalls and the halt cycle.
        if (cycle_cnt != CNT_MAX) begin
          cnt_nxt = cycle_cnt + CNT_W'(1);
        end
        if (halt) begin
          state_nxt = ST_DONE;
          pc_nxt    = prog_ctr;
        end else if (stall) begin
          pc_nxt    = prog_ctr;
        end else if (jump) begin
          pc_nxt    = jump_target;
        end else if (branch) begin
          pc_nxt    = pc_branch;
        end else begin
          pc_nxt    = pc_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: reset, start, branch/jump, stall/wrap, halt, mid-run reset.
// Latency: each step is one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: stall is exercised at the top of the address range, including the wrap to 0.
module tb_fetch_sequencer;

  localparam int D     = 9;
  localparam int OFF_W = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [D-1:0]     start_addr;
  logic             stall;
  logic             halt;
  logic             jump;
  logic [D-1:0]     jump_target;
  logic             branch;
  logic [OFF_W-1:0] branch_off;
  logic [D-1:0]     prog_ctr;
  logic             fetch_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.D(D), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .stall       (stall),
    .halt        (halt),
    .jump        (jump),
    .jump_target (jump_target),
    .branch      (branch),
    .branch_off  (branch_off),
    .prog_ctr    (prog_ctr),
    .fetch_valid (fetch_valid),
    .done        (done),
    .cycle_cnt   (cycle_cnt)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int pc, input int fv, input int dn, input int cnt);
    chk({tag, ".pc"},   32'(prog_ctr),    32'(pc));
    chk({tag, ".fv"},   32'(fetch_valid), 32'(fv));
    chk({tag, ".done"}, 32'(done),        32'(dn));
    chk({tag, ".cnt"},  32'(cycle_cnt),   32'(cnt));
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0; halt = 1'b0;
    jump = 1'b0; jump_target = '0; branch = 1'b0; branch_off = '0;

    // Reset held for two cycles.
    step(); step();
    chk_all("reset", 0, 0, 0, 0);

    // Release reset. The first edge after release only arms start.
    rst_n = 1'b1;
    step();
    chk_all("idle", 0, 0, 0, 0);

    // A jump while IDLE is ignored.
    jump = 1'b1; jump_target = 9'd123;
    step();
    chk_all("idle_jump", 0, 0, 0, 0);
    jump = 1'b0;

    // Start at 5, then four free-running cycles.
    start = 1'b1; start_addr = 9'd5;
    step();
    chk_all("start5", 5, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all("incr", 5 + i, 1, 0, i);
    end

    // Move to 20, then branch by -3.
    jump = 1'b1; jump_target = 9'd20;
    step();
    chk("jump20", 32'(prog_ctr), 20);
    jump = 1'b0;
    branch = 1'b1; branch_off = 8'hFD;
    step();
    chk("branch_m3", 32'(prog_ctr), 17);

    // Jump and branch together: jump wins.
    jump = 1'b1; jump_target = 9'd100;
    step();
    chk_all("jump_over_branch", 100, 1, 0, 7);
    branch = 1'b0;

    // Stall at the top address, then wrap.
    jump_target = 9'd511;
    step();
    chk_all("jump511", 511, 1, 0, 8);
    jump = 1'b0;
    stall = 1'b1;
    branch = 1'b1; branch_off = 8'h10;  // dropped because stall is high
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("stall.pc", 32'(prog_ctr), 511);
    end
    chk("stall.cnt", 32'(cycle_cnt), 11);
    stall = 1'b0; branch = 1'b0;
    step();
    chk_all("wrap", 0, 1, 0, 12);
    step();
    step();
    chk("pc2", 32'(prog_ctr), 2);
    branch = 1'b1; branch_off = 8'hFC;
    step();
    chk_all("branch_wrap", 510, 1, 0, 15);
    branch = 1'b0;

    // Halt with stall high at address 40.
    jump = 1'b1; jump_target = 9'd40;
    step();
    jump = 1'b0;
    chk("jump40", 32'(prog_ctr), 40);
    halt = 1'b1; stall = 1'b1;
    step();
    chk_all("halt", 40, 0, 1, 17);
    halt = 1'b0; stall = 1'b0;
    jump = 1'b1; jump_target = 9'd200;  // ignored in DONE
    step();
    step();
    chk_all("done_hold", 40, 0, 1, 17);
    jump = 1'b0;

    // Restart from DONE at address 0.
    start = 1'b1; start_addr = 9'd0;
    step();
    chk_all("restart0", 0, 1, 0, 0);

    // A start while in RUN is ignored.
    start_addr = 9'd300;
    step();
    chk_all("start_in_run", 1, 1, 0, 1);
    start = 1'b0;

    // Mid-run asynchronous reset at address 77.
    jump = 1'b1; jump_target = 9'd77;
    step();
    jump = 1'b0;
    chk("jump77", 32'(prog_ctr), 77);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    start = 1'b1; start_addr = 9'd33;
    step();
    chk_all("start_at_release", 0, 0, 0, 0);
    step();
    chk_all("start_after_release", 33, 1, 0, 0);
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
